inpkt_parser: RTL and testbench

Single-clock controller that drains the byte-wide first-word-fall-through side of the input FIFO and sequences it as framed input packets. It validates each 8-byte header, forwards payload bytes downstream through a one-deep registered output stage, and verifies a trailing payload checksum. On any protocol violation it halts FIFO reads until reset. It sits between the input FIFO read port and the packet-type decoders / word generators.

---
 rtl/inpkt_pkg.sv | 28 ++
 rtl/inpkt_parser_out_reg.sv | 40 ++++
 rtl/inpkt_parser.sv | 196 +++++++++++++++++++
 tb/tb_inpkt_parser.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inpkt_pkg.sv
// inpkt_pkg: shared constants and state encoding for the input packet parser.
//   HDR_BYTES     - number of header bytes in a frame
//   HDR_LAST_IDX  - byte index of the header checksum (hcs)
//   ERR_*         - bit positions inside the sticky err vector
//   state_t       - parser FSM encoding (also exported on dbg_state)
//   sum8          - modulo-256 byte accumulation used by both checksums
package inpkt_pkg;

  localparam int HDR_BYTES = 8;
  localparam logic [2:0] HDR_LAST_IDX = 3'(HDR_BYTES - 1);

  localparam int ERR_VERSION = 0;
  localparam int ERR_TYPE    = 1;
  localparam int ERR_LEN     = 2;
  localparam int ERR_CKSUM   = 3;

  typedef enum logic [1:0] {
    ST_HDR     = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_TRAILER = 2'd2,
    ST_ERROR   = 2'd3
  } state_t;

  function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/inpkt_parser_out_reg.sv
// out_reg_1deep: single-entry output register with a valid/rd handshake.
//   clk, rst  - clock, synchronous active-high reset
//   load      - capture din this cycle (caller only loads when can_load=1)
//   din       - entry to capture
//   rd        - consumer takes dout this cycle (meaningful while valid=1)
//   valid     - dout holds an entry
//   dout      - held entry; stable while valid=1 and rd=0
//   can_load  - register is empty or being emptied this cycle
//
// Handshake: an entry transfers on a clock edge where valid=1 and rd=1.
// A load on that same edge replaces the entry, so a steady stream moves
// one entry per cycle with no bubble.
module out_reg_1deep #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         rd,
  output logic         valid,
  output logic [W-1:0] dout,
  output logic         can_load
);

  assign can_load = !valid || rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (rd) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/inpkt_parser.sv
// inpkt_parser: drains a byte-wide FWFT FIFO and sequences framed packets.
// Frame: 8 header bytes (version, type, id lo/hi, len b0/b1/b2, hcs),
// len payload bytes, one trailer byte pcs. hcs/pcs are the bitwise
// complement of the modulo-256 sum of the bytes they cover.
//   clk, rst       - clock, synchronous active-high reset
//   fifo_dout      - FIFO head byte (valid while fifo_empty=0)
//   fifo_empty     - FIFO empty
//   fifo_rd_en     - pop FIFO head this cycle (combinational)
//   pkt_type/id/len- fields of the last accepted header
//   pkt_hdr_valid  - one-cycle pulse, header accepted
//   out_data/valid/last, out_rd - payload stream through a one-deep register
//   pkt_done       - one-cycle pulse, trailer checksum matched
//   err            - sticky {cksum, len, type, version}
//   halted         - parser stopped on a protocol violation
//   dbg_state      - current FSM state (state_t encoding)
//
// Handshake (out_*): a byte transfers on a clock edge where out_valid=1
// and out_rd=1. Downstream may only treat a packet as committed on pkt_done;
// out_last can be consumed before the trailer has been checked.
module inpkt_parser
  import inpkt_pkg::*;
#(
  parameter logic [7:0]  VERSION  = 8'd1,
  parameter int          MAX_TYPE = 3,
  parameter logic [23:0] MAX_LEN  = 24'd65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  fifo_dout,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  output logic [7:0]  pkt_type,
  output logic [15:0] pkt_id,
  output logic [23:0] pkt_len,
  output logic        pkt_hdr_valid,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_rd,
  output logic        pkt_done,
  output logic [3:0]  err,
  output logic        halted,
  output logic [1:0]  dbg_state
);

  localparam logic [7:0] MAX_TYPE_B = 8'(MAX_TYPE);

  state_t      state_q, state_next;
  logic [2:0]  idx_q;
  logic [23:0] cnt_q;
  logic [7:0]  sum_q;
  logic [7:0]  sum_next;
  // Header bytes 0..6 shift in from the top; after seven pops byte 0 sits
  // in [7:0] and byte 6 in [55:48], so the fields fall out as plain slices.
  logic [55:0] hdr_sr;

  logic [7:0]  hdr_ver;
  logic [7:0]  hdr_type;
  logic [15:0] hdr_id;
  logic [23:0] hdr_len;
  logic [3:0]  hdr_flags;
  logic        trl_ok;

  logic        pop;
  logic        load;
  logic        can_load;
  logic        last_in;
  logic [8:0]  oreg_q;

  assign hdr_ver  = hdr_sr[7:0];
  assign hdr_type = hdr_sr[15:8];
  assign hdr_id   = hdr_sr[31:16];
  assign hdr_len  = hdr_sr[55:32];
  assign sum_next = sum8(sum_q, fifo_dout);

  // Only meaningful while fifo_dout is the hcs byte (HDR, index 7).
  assign hdr_flags[ERR_VERSION] = (hdr_ver != VERSION);
  assign hdr_flags[ERR_TYPE]    = (hdr_type == 8'd0) || (hdr_type > MAX_TYPE_B);
  assign hdr_flags[ERR_LEN]     = (hdr_len == 24'd0) || (hdr_len > MAX_LEN);
  assign hdr_flags[ERR_CKSUM]   = (fifo_dout != ~sum_q);

  assign trl_ok  = (fifo_dout == ~sum_q);
  assign last_in = (cnt_q == 24'd1);

  always_comb begin
    state_next = state_q;
    pop        = 1'b0;
    load       = 1'b0;
    unique case (state_q)
      ST_HDR: begin
        pop = !fifo_empty;
        if (pop && (idx_q == HDR_LAST_IDX)) begin
          state_next = (hdr_flags == 4'd0) ? ST_PAYLOAD : ST_ERROR;
        end
      end
      ST_PAYLOAD: begin
        pop  = !fifo_empty && can_load;
        load = pop;
        if (pop && last_in) begin
          state_next = ST_TRAILER;
        end
      end
      ST_TRAILER: begin
        pop = !fifo_empty;
        if (pop) begin
          state_next = trl_ok ? ST_HDR : ST_ERROR;
        end
      end
      ST_ERROR: begin
        pop = 1'b0;
      end
      default: begin
        state_next = ST_ERROR;
      end
    endcase
  end

  // No pops while held in reset: a byte taken then would be lost.
  assign fifo_rd_en = pop && !rst;
  assign halted     = (state_q == ST_ERROR);
  assign dbg_state  = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_HDR;
      idx_q         <= 3'd0;
      cnt_q         <= 24'd0;
      sum_q         <= 8'd0;
      hdr_sr        <= 56'd0;
      pkt_type      <= 8'd0;
      pkt_id        <= 16'd0;
      pkt_len       <= 24'd0;
      pkt_hdr_valid <= 1'b0;
      pkt_done      <= 1'b0;
      err           <= 4'd0;
    end else begin
      state_q       <= state_next;
      pkt_hdr_valid <= 1'b0;
      pkt_done      <= 1'b0;
      unique case (state_q)
        ST_HDR: begin
          if (pop) begin
            idx_q <= idx_q + 3'd1;
            sum_q <= sum_next;
            if (idx_q != HDR_LAST_IDX) begin
              hdr_sr <= {fifo_dout, hdr_sr[55:8]};
            end else if (hdr_flags == 4'd0) begin
              pkt_type      <= hdr_type;
              pkt_id        <= hdr_id;
              pkt_len       <= hdr_len;
              pkt_hdr_valid <= 1'b1;
              cnt_q         <= hdr_len;
              sum_q         <= 8'd0;
            end else begin
              err <= err | hdr_flags;
            end
          end
        end
        ST_PAYLOAD: begin
          if (pop) begin
            cnt_q <= cnt_q - 24'd1;
            sum_q <= sum_next;
          end
        end
        ST_TRAILER: begin
          if (pop) begin
            if (trl_ok) begin
              pkt_done <= 1'b1;
              sum_q    <= 8'd0;
              idx_q    <= 3'd0;
            end else begin
              err[ERR_CKSUM] <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  out_reg_1deep #(.W(9)) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .din      ({last_in, fifo_dout}),
    .rd       (out_rd),
    .valid    (out_valid),
    .dout     (oreg_q),
    .can_load (can_load)
  );

  assign out_data = oreg_q[7:0];
  assign out_last = oreg_q[8];

endmodule

// File: tb/tb_inpkt_parser.sv
module tb_inpkt_parser;

  logic        clk;
  logic        rst;
  logic [7:0]  fifo_dout;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [7:0]  pkt_type;
  logic [15:0] pkt_id;
  logic [23:0] pkt_len;
  logic        pkt_hdr_valid;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_rd;
  logic        pkt_done;
  logic [3:0]  err;
  logic        halted;
  logic [1:0]  dbg_state;

  inpkt_parser dut (
    .clk           (clk),
    .rst           (rst),
    .fifo_dout     (fifo_dout),
    .fifo_empty    (fifo_empty),
    .fifo_rd_en    (fifo_rd_en),
    .pkt_type      (pkt_type),
    .pkt_id        (pkt_id),
    .pkt_len       (pkt_len),
    .pkt_hdr_valid (pkt_hdr_valid),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_last      (out_last),
    .out_rd        (out_rd),
    .pkt_done      (pkt_done),
    .err           (err),
    .halted        (halted),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bench state ----------------
  int          vectors;
  int          miscompares;
  logic [8:0]  exp_q[$];      // {last, data} expected on the output stream
  logic [47:0] exp_hdr_q[$];  // {type, id, len} expected on pkt_hdr_valid
  logic [7:0]  fifo_q[$];     // FIFO model contents
  logic [7:0]  pl_q[$];       // payload for the next send_frame
  int          exp_done;
  int          done_cnt;
  logic [3:0]  exp_err;
  bit          model_halted;
  int          stall_pct;
  int          rd_pct;
  bit          pop_pending;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- FIFO / downstream driver ----------------
  always @(posedge clk) begin
    #1;
    if (pop_pending && fifo_q.size() > 0) void'(fifo_q.pop_front());
    fifo_empty = (fifo_q.size() == 0) || (int'($urandom_range(0, 99)) < stall_pct);
    fifo_dout  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    out_rd     = int'($urandom_range(0, 99)) < rd_pct;
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    pop_pending = fifo_rd_en;
    if (fifo_rd_en) check("rd_en_while_empty", 64'(fifo_empty), 64'd0);
    if (!rst) begin
      if (out_valid && out_rd) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL out_unexpected: got %0h expected none", {out_last, out_data});
        end else begin
          check("out_byte", 64'({out_last, out_data}), 64'(exp_q.pop_front()));
        end
      end
      if (pkt_hdr_valid) begin
        if (exp_hdr_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL hdr_unexpected: got %0h expected none", {pkt_type, pkt_id, pkt_len});
        end else begin
          check("hdr_fields", 64'({pkt_type, pkt_id, pkt_len}), 64'(exp_hdr_q.pop_front()));
        end
      end
      if (pkt_done) done_cnt++;
    end
  end

  // ---------------- reference model + stimulus ----------------
  // Builds the byte frame and decides, from the framing rules alone, what
  // the parser must report for it.
  task automatic send_frame(input logic [7:0] ver, input logic [7:0] typ,
                            input logic [15:0] id, input logic [23:0] len,
                            input bit bad_hcs, input bit bad_pcs);
    logic [7:0] h [8];
    logic [7:0] s;
    logic [7:0] pcs;
    logic [3:0] flags;
    h[0] = ver;       h[1] = typ;
    h[2] = id[7:0];   h[3] = id[15:8];
    h[4] = len[7:0];  h[5] = len[15:8];  h[6] = len[23:16];
    s = 8'd0;
    for (int i = 0; i < 7; i++) s = s + h[i];
    h[7] = ~s ^ (bad_hcs ? 8'h01 : 8'h00);
    s = 8'd0;
    for (int i = 0; i < pl_q.size(); i++) s = s + pl_q[i];
    pcs = ~s ^ (bad_pcs ? 8'h80 : 8'h00);
    for (int i = 0; i < 8; i++) fifo_q.push_back(h[i]);
    for (int i = 0; i < pl_q.size(); i++) fifo_q.push_back(pl_q[i]);
    fifo_q.push_back(pcs);

    if (!model_halted) begin
      flags[0] = (ver != 8'd1);
      flags[1] = (typ == 8'd0) || (typ > 8'd3);
      flags[2] = (len == 24'd0) || (len > 24'd65536);
      flags[3] = bad_hcs;
      if (flags != 4'd0) begin
        exp_err = exp_err | flags;
        model_halted = 1'b1;
      end else begin
        exp_hdr_q.push_back({typ, id, len});
        for (int i = 0; i < pl_q.size(); i++)
          exp_q.push_back({(i == pl_q.size() - 1), pl_q[i]});
        if (bad_pcs) begin
          exp_err[3] = 1'b1;
          model_halted = 1'b1;
        end else begin
          exp_done++;
        end
      end
    end
  endtask

  task automatic fill_payload(input int n);
    pl_q.delete();
    for (int i = 0; i < n; i++) pl_q.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_fifo_rd_en"}, 64'(fifo_rd_en), 64'd0);
    check({tag, "_fields"}, 64'({pkt_type, pkt_id, pkt_len}), 64'd0);
    check({tag, "_pulses"}, 64'({pkt_hdr_valid, pkt_done}), 64'd0);
    check({tag, "_out"}, 64'({out_valid, out_last}), 64'd0);
    check({tag, "_out_data"}, 64'(out_data), 64'd0);
    check({tag, "_err_halt"}, 64'({err, halted}), 64'd0);
  endtask

  task automatic reset_dut(input string tag);
    @(posedge clk);
    #1;
    rst = 1'b1;
    fifo_q.delete();
    exp_q.delete();
    exp_hdr_q.delete();
    exp_done = 0;
    done_cnt = 0;
    exp_err = 4'd0;
    model_halted = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_all_zero(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_settle(input string tag, input bit expect_halt);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 4000 && !ok; c++) begin
      @(negedge clk);
      if (expect_halt)
        ok = halted && exp_q.size() == 0 && !out_valid;
      else
        ok = fifo_q.size() == 0 && exp_q.size() == 0 && exp_hdr_q.size() == 0 &&
             !out_valid && done_cnt == exp_done;
    end
    check({tag, "_settle_in_time"}, 64'(ok), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic end_checks(input string tag);
    check({tag, "_out_left"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_hdr_left"}, 64'(exp_hdr_q.size()), 64'd0);
    check({tag, "_done_cnt"}, 64'(done_cnt), 64'(exp_done));
    check({tag, "_err"}, 64'(err), 64'(exp_err));
    check({tag, "_halted"}, 64'(halted), 64'(model_halted));
  endtask

  // ---------------- test sequence ----------------
  typedef struct {
    logic [7:0]  ver;
    logic [7:0]  typ;
    logic [23:0] len;
    bit          bad_hcs;
  } bad_hdr_t;

  bad_hdr_t bad_tbl [5];
  bit mid_ok;

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; out_rd = 1'b0; fifo_empty = 1'b1; fifo_dout = 8'h00;
    stall_pct = 0; rd_pct = 100; pop_pending = 1'b0;
    exp_done = 0; done_cnt = 0; exp_err = 4'd0; model_halted = 1'b0;

    reset_dut("reset");

    // Reference packet, full-rate downstream.
    pl_q = '{8'hAA, 8'hBB, 8'hCC};
    send_frame(8'd1, 8'd2, 16'h1234, 24'd3, 1'b0, 1'b0);
    wait_settle("basic", 1'b0);
    end_checks("basic");

    // Same packet with back-pressure and FIFO bubbles.
    stall_pct = 30; rd_pct = 50;
    pl_q = '{8'hAA, 8'hBB, 8'hCC};
    send_frame(8'd1, 8'd2, 16'h1234, 24'd3, 1'b0, 1'b0);
    wait_settle("stall", 1'b0);
    end_checks("stall");

    // Random back-to-back packets, including the len=1 and type=MAX edges.
    stall_pct = 20; rd_pct = 70;
    pl_q = '{8'h5A};
    send_frame(8'd1, 8'd3, 16'hFFFF, 24'd1, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      int n;
      n = int'($urandom_range(1, 24));
      fill_payload(n);
      send_frame(8'd1, 8'($urandom_range(1, 3)), 16'($urandom), 24'(n), 1'b0, 1'b0);
    end
    wait_settle("random", 1'b0);
    end_checks("random");

    // Bad trailer checksum: payload still delivered, no pkt_done.
    fill_payload(5);
    send_frame(8'd1, 8'd3, 16'hBEEF, 24'd5, 1'b0, 1'b1);
    wait_settle("bad_pcs", 1'b1);
    end_checks("bad_pcs");

    // Version 2 and type 0 together; parser must stay off the FIFO.
    reset_dut("reset_ver");
    fill_payload(4);
    send_frame(8'd2, 8'd0, 16'h0001, 24'd4, 1'b0, 1'b0);
    wait_settle("ver_type", 1'b1);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      check("halt_rd_en", 64'(fifo_rd_en), 64'd0);
    end
    end_checks("ver_type");
    check("ver_type_err_bits", 64'(err), 64'h3);

    // Remaining header violations, one per reset.
    bad_tbl[0] = '{ver: 8'd1, typ: 8'd1, len: 24'h010001, bad_hcs: 1'b0};
    bad_tbl[1] = '{ver: 8'd1, typ: 8'd4, len: 24'd2,      bad_hcs: 1'b0};
    bad_tbl[2] = '{ver: 8'd1, typ: 8'd2, len: 24'd0,      bad_hcs: 1'b0};
    bad_tbl[3] = '{ver: 8'd1, typ: 8'd2, len: 24'd2,      bad_hcs: 1'b1};
    bad_tbl[4] = '{ver: 8'd7, typ: 8'd9, len: 24'hFFFFFF, bad_hcs: 1'b1};
    for (int t = 0; t < 5; t++) begin
      reset_dut("reset_bad");
      fill_payload(2);
      send_frame(bad_tbl[t].ver, bad_tbl[t].typ, 16'h00A5, bad_tbl[t].len,
                 bad_tbl[t].bad_hcs, 1'b0);
      wait_settle("bad_hdr", 1'b1);
      end_checks("bad_hdr");
    end

    // Two packets, then reset in the middle of a third.
    reset_dut("reset_b2b");
    stall_pct = 10; rd_pct = 80;
    fill_payload(6);
    send_frame(8'd1, 8'd1, 16'h0102, 24'd6, 1'b0, 1'b0);
    fill_payload(9);
    send_frame(8'd1, 8'd2, 16'h0304, 24'd9, 1'b0, 1'b0);
    fill_payload(16);
    send_frame(8'd1, 8'd3, 16'h0506, 24'd16, 1'b0, 1'b0);
    mid_ok = 1'b0;
    for (int c = 0; c < 2000 && !mid_ok; c++) begin
      @(negedge clk);
      mid_ok = done_cnt == 2 && dbg_state == 2'd1 && exp_q.size() <= 12;
    end
    check("mid_payload_reached", 64'(mid_ok), 64'd1);
    check("b2b_done_cnt", 64'(done_cnt), 64'd2);
    reset_dut("mid_reset");

    fill_payload(7);
    send_frame(8'd1, 8'd2, 16'hCAFE, 24'd7, 1'b0, 1'b0);
    wait_settle("after_reset", 1'b0);
    end_checks("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
